// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter: buffers each N_FFT-sample symbol and replays its last CP_LEN samples ahead of it.
// Latency: sop_out rises 2 edges after the edge accepting sample N_FFT-1 (full flag, then RAM read into output reg).
// Backpressure: ready_out drops only while both ping-pong buffers are full; the output holds while valid_out && !ready_in.
// Optional build macro OFDM_CP_ERRCNT_EN adds the 8-bit saturating err_cnt port and counts HUNT drops as errors.
module ofdm_cp_inserter #(
   parameter int N_FFT  = 64,
   parameter int CP_LEN = 16,
   parameter int W      = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic signed [W-1:0] i_in,
   input  logic signed [W-1:0] q_in,
   input  logic                valid_in,
   input  logic                sop_in,
   output logic                ready_out,
   output logic signed [W-1:0] i_out,
   output logic signed [W-1:0] q_out,
   output logic                valid_out,
   output logic                sop_out,
   output logic                eop_out,
   input  logic                ready_in,
`ifdef OFDM_CP_ERRCNT_EN
   output logic [7:0]          err_cnt,
`endif
   output logic                sync_err
);

   localparam int AW = $clog2(N_FFT);
   localparam logic [AW-1:0] IDX_LAST = AW'(N_FFT - 1);
   localparam logic [AW-1:0] IDX_CP0  = AW'(N_FFT - CP_LEN);

   typedef enum logic {
      W_HUNT,
      W_FILL
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_CP,
      R_BODY
   } rd_state_t;

   // Two symbol buffers: address MSB selects the buffer, low bits the sample index.
   logic [2*W-1:0] mem [2*N_FFT];

   // Write side
   wr_state_t     wr_state;
   wr_state_t     wr_state_nxt;
   logic          wr_buf;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] wr_ptr;
   logic          wr_en;
   logic          set_full;
   logic          resync;
   logic          err_set;
   logic          accept;

   // Buffer ownership
   logic [1:0]    full;
   logic [1:0]    full_nxt;

   // Read side
   rd_state_t     rd_state;
   rd_state_t     rd_state_nxt;
   logic          rd_buf;
   logic [AW-1:0] rd_idx;
   logic          adv;
   logic          rd_fire;
   logic          first_cp;
   logic          last_body;
   logic          free_buf;

   assign accept = valid_in && ready_out;
   assign adv    = !valid_out || ready_in;

   // ------------------------------------------------------------------
   // Write FSM
   // ------------------------------------------------------------------

   // Write FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_state <= W_HUNT;
      end else begin
         wr_state <= wr_state_nxt;
      end
   end

   // Write FSM next state: a sop starts a fill, the last index ends it
   always_comb begin
      wr_state_nxt = wr_state;
      unique case (wr_state)
         W_HUNT: begin
            if (accept && sop_in) begin
               wr_state_nxt = W_FILL;
            end
         end
         W_FILL: begin
            if (set_full) begin
               wr_state_nxt = W_HUNT;
            end
         end
         default: wr_state_nxt = W_HUNT;
      endcase
   end

   // Write FSM outputs: RAM write strobe/index, buffer-complete and resync events
   always_comb begin
      wr_en    = 1'b0;
      wr_ptr   = wr_idx;
      set_full = 1'b0;
      resync   = 1'b0;
      if (accept) begin
         unique case (wr_state)
            W_HUNT: begin
               if (sop_in) begin
                  wr_en  = 1'b1;
                  wr_ptr = '0;
               end
            end
            W_FILL: begin
               wr_en = 1'b1;
               if (sop_in) begin
                  // A new sop mid-fill restarts the same buffer from index 0.
                  wr_ptr = '0;
                  resync = 1'b1;
               end else if (wr_idx == IDX_LAST) begin
                  set_full = 1'b1;
               end
            end
            default: wr_en = 1'b0;
         endcase
      end
   end

`ifdef OFDM_CP_ERRCNT_EN
   logic hunt_drop;
   assign hunt_drop = accept && (wr_state == W_HUNT) && !sop_in;
   assign err_set   = resync || hunt_drop;
`else
   assign err_set   = resync;
`endif

   // Write index and buffer pointer; the pointer flips once a symbol is complete
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_idx <= '0;
         wr_buf <= 1'b0;
      end else if (wr_en) begin
         if (set_full) begin
            wr_idx <= '0;
            wr_buf <= ~wr_buf;
         end else begin
            wr_idx <= wr_ptr + AW'(1);
         end
      end
   end

   // Sample storage write port (no reset: contents are qualified by the full flags)
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[{wr_buf, wr_ptr}] <= {i_in, q_in};
      end
   end

   // ------------------------------------------------------------------
   // Buffer full flags and upstream ready
   // ------------------------------------------------------------------

   // Fill and free may hit different buffers on the same edge; both take effect
   always_comb begin
      full_nxt = full;
      if (set_full) begin
         full_nxt[wr_buf] = 1'b1;
      end
      if (free_buf) begin
         full_nxt[rd_buf] = 1'b0;
      end
   end

   // Full flags and registered ready_out derived from the next flag state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         full      <= 2'b00;
         ready_out <= 1'b1;
      end else begin
         full      <= full_nxt;
         ready_out <= ~(&full_nxt);
      end
   end

   // ------------------------------------------------------------------
   // Read FSM
   // ------------------------------------------------------------------

   // Read FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_state <= R_IDLE;
      end else begin
         rd_state <= rd_state_nxt;
      end
   end

   // Read FSM next state: IDLE -> CP -> BODY, chaining straight into the next full buffer
   always_comb begin
      rd_state_nxt = rd_state;
      unique case (rd_state)
         R_IDLE: begin
            if (full[rd_buf]) begin
               rd_state_nxt = R_CP;
            end
         end
         R_CP: begin
            if (adv && (rd_idx == IDX_LAST)) begin
               rd_state_nxt = R_BODY;
            end
         end
         R_BODY: begin
            if (adv && (rd_idx == IDX_LAST)) begin
               rd_state_nxt = full[~rd_buf] ? R_CP : R_IDLE;
            end
         end
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   // Read FSM outputs: read strobe, frame markers and buffer release
   always_comb begin
      rd_fire   = 1'b0;
      first_cp  = 1'b0;
      last_body = 1'b0;
      free_buf  = 1'b0;
      unique case (rd_state)
         R_CP: begin
            rd_fire  = adv;
            first_cp = (rd_idx == IDX_CP0);
         end
         R_BODY: begin
            rd_fire   = adv;
            last_body = (rd_idx == IDX_LAST);
            free_buf  = adv && (rd_idx == IDX_LAST);
         end
         default: rd_fire = 1'b0;
      endcase
   end

   // Read index and buffer pointer; the index jumps to the CP start for each new symbol
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_idx <= '0;
         rd_buf <= 1'b0;
      end else if (rd_state == R_IDLE) begin
         if (full[rd_buf]) begin
            rd_idx <= IDX_CP0;
         end
      end else if (adv) begin
         if (rd_idx == IDX_LAST) begin
            if (rd_state == R_CP) begin
               rd_idx <= '0;
            end else begin
               rd_idx <= IDX_CP0;
               rd_buf <= ~rd_buf;
            end
         end else begin
            rd_idx <= rd_idx + AW'(1);
         end
      end
   end

   // Output register doubles as the RAM read register; it only loads when downstream can take it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         i_out     <= '0;
         q_out     <= '0;
         valid_out <= 1'b0;
         sop_out   <= 1'b0;
         eop_out   <= 1'b0;
      end else if (adv) begin
         valid_out <= rd_fire;
         if (rd_fire) begin
            {i_out, q_out} <= mem[{rd_buf, rd_idx}];
            sop_out        <= first_cp;
            eop_out        <= last_body;
         end else begin
            sop_out <= 1'b0;
            eop_out <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Error reporting
   // ------------------------------------------------------------------

   // Sticky resync flag, cleared only by reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_err <= 1'b0;
      end else if (err_set) begin
         sync_err <= 1'b1;
      end
   end

`ifdef OFDM_CP_ERRCNT_EN
   // Saturating count of resync events and HUNT drops
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_cnt <= 8'd0;
      end else if (err_set && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule
